serial_logic_unit: RTL and testbench

SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

---
 rtl/serial_logic_unit_pkg.sv | 19 +
 rtl/chunk_logic.sv | 29 ++
 rtl/serial_logic_unit.sv | 135 +++++++++++++
 tb/tb_serial_logic_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_logic_unit_pkg.sv
// rtl/serial_logic_unit_pkg.sv - shared op codes and FSM state encodings for the serial logic unit
// Purpose: common types imported by serial_logic_unit and chunk_logic.
// Ports: none (package).
package serial_logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/chunk_logic.sv
// rtl/chunk_logic.sv - bitwise AND/OR/XOR/XNOR of one c-bit chunk
// Purpose: per-chunk combinational function used by the serial logic unit.
// Ports:
//   a, b : c-bit operand chunks
//   op   : operation select (op_e)
//   r    : c-bit result chunk
module chunk_logic
    import serial_logic_unit_pkg::*;
#(
    parameter int c = 4
) (
    input  logic [c-1:0] a,
    input  logic [c-1:0] b,
    input  op_e          op,
    output logic [c-1:0] r
);

    always_comb begin
        r = '0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/serial_logic_unit.sv
// rtl/serial_logic_unit.sv - chunk-serial bitwise logic unit with start/busy/done handshake
// Purpose: latches x, y, op on an accepted start, produces z one c-bit chunk per
//          cycle (LSB chunk first), then pulses done with registered zero/parity flags.
// Ports:
//   clk    : clock, rising edge
//   rst_b  : asynchronous active-low reset
//   start  : begin an operation (accepted in IDLE or DONE)
//   op     : 00 AND, 01 OR, 10 XOR, 11 XNOR
//   x, y   : w-bit operands
//   z      : w-bit result register
//   busy   : high in BUSY
//   done   : high in DONE (one cycle)
//   zero   : completed z == 0
//   parity : XOR-reduction of completed z
module serial_logic_unit
    import serial_logic_unit_pkg::*;
#(
    parameter int w = 16,
    parameter int c = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [w-1:0] x,
    input  logic [w-1:0] y,
    output logic [w-1:0] z,
    output logic         busy,
    output logic         done,
    output logic         zero,
    output logic         parity
);

    localparam int              NCHUNK = w / c;
    localparam int              CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]   LAST   = CW'(NCHUNK - 1);

    state_e         r_state;
    state_e         w_next_state;
    logic [CW-1:0]  r_cnt;
    logic [w-1:0]   r_x;
    logic [w-1:0]   r_y;
    logic [w-1:0]   r_z;
    op_e            r_op;
    logic           r_zero;
    logic           r_parity;

    logic [c-1:0]   w_a;
    logic [c-1:0]   w_b;
    logic [c-1:0]   w_r;
    logic [w-1:0]   w_z_next;
    logic           w_accept;
    logic           w_last;

    assign w_a    = r_x[int'(r_cnt) * c +: c];
    assign w_b    = r_y[int'(r_cnt) * c +: c];
    assign w_last = (r_cnt == LAST);

    chunk_logic #(.c(c)) u_chunk (
        .a  (w_a),
        .b  (w_b),
        .op (r_op),
        .r  (w_r)
    );

    // Full result after this cycle's chunk lands; the flags are taken from this
    // on the final chunk so they see the complete word, not the stale r_z.
    always_comb begin
        w_z_next = r_z;
        w_z_next[int'(r_cnt) * c +: c] = w_r;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next_state = BUSY;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_op     <= OP_AND;
            r_z      <= '0;
            r_zero   <= 1'b0;
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_x   <= x;
            r_y   <= y;
            r_op  <= op_e'(op);
            r_z   <= '0;
        end else if (r_state == BUSY) begin
            r_z <= w_z_next;
            if (w_last) begin
                r_cnt    <= '0;
                r_zero   <= ~|w_z_next;
                r_parity <= ^w_z_next;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign z      = r_z;
    assign busy   = (r_state == BUSY);
    assign done   = (r_state == DONE);
    assign zero   = r_zero;
    assign parity = r_parity;

endmodule

// File: tb/tb_serial_logic_unit.sv
// tb/tb_serial_logic_unit.sv - self-checking bench for serial_logic_unit
module tb_serial_logic_unit;

    typedef struct packed {
        logic [15:0] z;
        logic        zero;
        logic        parity;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic [15:0] z;
    logic        busy;
    logic        done;
    logic        zero;
    logic        parity;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    serial_logic_unit #(.w(16), .c(4)) dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .start  (start),
        .op     (op),
        .x      (x),
        .y      (y),
        .z      (z),
        .busy   (busy),
        .done   (done),
        .zero   (zero),
        .parity (parity)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o);
        exp_t e;
        case (o)
            2'b00:   e.z = a & b;
            2'b01:   e.z = a | b;
            2'b10:   e.z = a ^ b;
            default: e.z = ~(a ^ b);
        endcase
        e.zero   = (e.z == 16'h0000);
        e.parity = ^e.z;
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_b && done) begin
            if (sb.size() == 0) begin
                check("done_without_pending_op", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("z", 32'(z), 32'(e.z));
                check("zero", 32'(zero), 32'(e.zero));
                check("parity", 32'(parity), 32'(e.parity));
            end
        end
    end

    // One operation with scrambled inputs and stray start pulses while busy.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o);
        int   n;
        exp_t e;
        e = model(a, b, o);
        @(negedge clk);
        x = a; y = b; op = o; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        n = 0;
        while (!done && n < 20) begin
            check("busy_during_op", 32'(busy), 32'd1);
            n++;
            start = 1'($urandom_range(0, 1));
            x = 16'($urandom);
            y = 16'($urandom);
            op = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        start = 1'b0;
        check("done_latency", 32'(n), 32'd4);
        check("busy_low_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_single_pulse", 32'(done), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
        check("z_hold_idle", 32'(z), 32'(e.z));
        check("parity_hold_idle", 32'(parity), 32'(e.parity));
    endtask

    initial begin
        #2 rst_b = 1'b0;
        #1;
        check("rst_z", 32'(z), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_parity", 32'(parity), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;

        do_op(16'hF0F0, 16'hFF00, 2'b00);
        do_op(16'hF0F0, 16'hFF00, 2'b01);
        do_op(16'hF0F0, 16'hFF00, 2'b10);
        do_op(16'hF0F0, 16'hFF00, 2'b11);
        do_op(16'h00FF, 16'hFF00, 2'b00);
        do_op(16'h0001, 16'h0000, 2'b01);

        // start held high: accept every 5 cycles, done on the same cycle as the next accept
        for (int cyc = 0; cyc <= 15; cyc++) begin
            @(negedge clk);
            check("b2b_done", 32'(done), 32'((cyc > 0) && (cyc % 5 == 0)));
            check("b2b_busy", 32'(busy), 32'(cyc % 5 != 0));
            if (cyc == 15) begin
                start = 1'b0;
            end else begin
                start = 1'b1;
                x = 16'($urandom);
                y = 16'($urandom);
                op = 2'($urandom_range(0, 3));
                if (cyc % 5 == 0) sb.push_back(model(x, y, op));
            end
        end
        @(negedge clk);
        check("b2b_queue_drained", 32'(sb.size()), 32'd0);

        // reset during the second BUSY cycle abandons the op
        @(negedge clk);
        x = 16'hFFFF; y = 16'hFFFF; op = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_partial_z", 32'(z), 32'h000F);
        #1 rst_b = 1'b0;
        #1;
        check("midrst_z", 32'(z), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_zero", 32'(zero), 32'd0);
        check("midrst_parity", 32'(parity), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_done_after_rst", 32'(done), 32'd0);
        end
        do_op(16'h1234, 16'hFFFF, 2'b10);
        check("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
